ring_counter_mm: RTL and testbench
==================================

// Module: ring_counter_mm
// PURPOSE
//   Parametrised multi-mode ring counter. Replaces the fixed-length one-hot ring used for cycle sequencing.
//   Adds the following:
//   - one-hot ring or Johnson (twisted-ring) mode;
//   - up/down direction and count enable;
//   - synchronous preload;
//   - terminal-count pulse and revolution counter.
//   It sits in sequencing/timing paths that need phase strobes spaced C_WIDTH (ring) or 2*C_WIDTH (Johnson) cycles apart.
// PARAMETERS
//   C_WIDTH     4  number of stages (state bits); legal range >= 2
//   C_REV_BITS  8  width of the revolution counter REV_CNT; legal range >= 1
// PORTS
//   CK        in   1           clock, rising edge
//   RST       in   1           asynchronous reset, active low
//   EN        in   1           advance enable
//   DIR       in   1           0 = up (shift toward MSB), 1 = down (shift toward LSB)
//   MODE      in   1           0 = one-hot ring, 1 = Johnson
//   LOAD      in   1           synchronous preload strobe
//   LOAD_VAL  in   C_WIDTH     preload value
//   Q         out  C_WIDTH     counter state
//   TC        out  1           terminal-count pulse (combinational from registered state and inputs)
//   REV_CNT   out  C_REV_BITS  completed revolutions, modulo 2^C_REV_BITS
//   ERR       out  1           sticky illegal-state flag (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (RST=0, async):
//     - Q = {0..0,1}; REV_CNT = 0; ERR = 0.
//     - Internal registered mode mode_q = 0.
//     - Release is synchronous to CK; the first advance happens on the first CK edge with RST=1 and EN=1.
//   - Home state H: ring H = {0..0,1}; Johnson H = all zeros.
//   - Next state, when advancing (W = C_WIDTH):
//     - ring up:      {Q[W-2:0], Q[W-1]}
//     - ring down:    {Q[0], Q[W-1:1]}
//     - Johnson up:   {Q[W-2:0], ~Q[W-1]}
//     - Johnson down: {~Q[0], Q[W-1:1]}
//   - Per-edge priority, highest first:
//     1. LOAD: Q <= LOAD_VAL; REV_CNT unchanged; no TC.
//     2. MODE != mode_q: Q <= H of the new mode; mode_q <= MODE; REV_CNT <= 0; no advance, no TC (one-cycle switch).
//     3. EN: Q <= next state.
//     4. Otherwise hold.
//   - TC = EN & ~LOAD & (MODE == mode_q) & (next state == H).
//     - One pulse per revolution: every C_WIDTH advances in ring mode, every 2*C_WIDTH in Johnson mode.
//     - Ring up: TC is high while Q = {1,0..0}. Ring down: TC is high while Q = {0..0,1,0}.
//     - Changing DIR mid-revolution is legal. State reverses on the next edge; TC follows the equation above.
//   - REV_CNT increments on each edge where TC = 1. It wraps from 2^C_REV_BITS-1 to 0 with no flag.
//   - Latency: Q changes one edge after inputs are sampled; no pipeline.
//   - Mid-operation async reset abandons any in-progress revolution; no partial state is retained.
// CONFIGURATION
//   Macro RING_CNT_ERR_DETECT_EN
//   - Defined:
//     - Legal states: ring = exactly one bit set; Johnson = a valid twisted pattern (zeros-then-ones or ones-then-zeros).
//     - An illegal Q (from LOAD_VAL or an upset) is detected in the cycle it appears.
//     - On the next edge Q is forced to H (this overrides EN; LOAD still wins). ERR goes to 1 and stays set until RST.
//   - Not defined: no checking; illegal patterns shift per the equations above; ERR is tied to 0.
// STRUCTURE
//   Package ring_counter_pkg holds:
//   - typedef enum {RC_RING, RC_JOHNSON} for MODE;
//   - function rc_home(mode, width) and function rc_next(q, mode, dir);
//   - function rc_legal(q, mode).
//   Sub-module ring_state_check: a combinational legality checker using rc_legal, instantiated only under RING_CNT_ERR_DETECT_EN.
//   The rest (state register, mode register, REV_CNT) lives in ring_counter_mm.
// TESTING (C_WIDTH=4, C_REV_BITS=2)
//   1. Reset, MODE=0, DIR=0, EN=1 for 8 edges.
//      -> Q = 0001,0010,0100,1000,0001,...
//      -> TC high while Q=1000 (twice); REV_CNT=2.
//   2. MODE=1 from reset.
//      -> First edge: Q=0000, REV_CNT=0.
//      -> Then 0001,0011,0111,1111,1110,1100,1000,0000.
//      -> TC high at Q=1000; period 8.
//   3. Ring up; at Q=0100 set DIR=1.
//      -> Q = 0010,0001,1000.
//      -> TC high at Q=0010 only.
//   4. Ring EN=1 with LOAD=1, LOAD_VAL=0100 in the cycle Q=1000.
//      -> Q=0100 next; no TC; REV_CNT unchanged.
//      -> Then 1000 (TC), 0001.
//   5. Run ring for 16 revolutions.
//      -> REV_CNT sequence 1,2,3,0,...; wraps silently.
//   6. With the macro defined: LOAD_VAL=0110 in ring mode.
//      -> Q=0110 for 1 cycle, then 0001; ERR=1 and held until RST.
//      -> Without the macro: Q = 1100,1001,...; ERR=0.

Source files
------------

// File: rtl/ring_counter_pkg.sv
// Shared types and helper functions for the multi-mode ring counter.
// Vectors are carried at RC_MAX_W bits; bits at and above the active width are always zero.
package ring_counter_pkg;

  localparam int RC_MAX_W = 64;
  localparam int RC_IDX_W = 6;

  typedef logic [RC_MAX_W-1:0] rc_vec_t;
  typedef logic [RC_IDX_W-1:0] rc_idx_t;

  typedef enum logic {
    RC_RING    = 1'b0,
    RC_JOHNSON = 1'b1
  } rc_mode_e;

  // Ones in bits [width-1:0], zeros above.
  function automatic rc_vec_t rc_mask(int width);
    rc_vec_t m;
    for (int i = 0; i < RC_MAX_W; i++) begin
      m[i] = (i < width);
    end
    return m;
  endfunction

  function automatic rc_vec_t rc_home(rc_mode_e mode, int width);
    rc_vec_t h;
    h = (mode == RC_RING) ? rc_vec_t'(1) : '0;
    return h & rc_mask(width);
  endfunction

  // One advance step; Johnson differs from ring only by the inverted feedback bit.
  function automatic rc_vec_t rc_next(rc_vec_t q, rc_mode_e mode, logic dir, int width);
    rc_vec_t n;
    rc_idx_t msb;
    logic    twist;
    msb   = rc_idx_t'(width - 1);
    twist = (mode == RC_JOHNSON);
    if (!dir) begin
      n    = q << 1;
      n[0] = q[msb] ^ twist;
    end else begin
      n      = q >> 1;
      n[msb] = q[0] ^ twist;
    end
    return n & rc_mask(width);
  endfunction

  // Ring: exactly one bit set. Johnson: at most one boundary between adjacent bits.
  function automatic logic rc_legal(rc_vec_t q, rc_mode_e mode, int width);
    rc_vec_t edges;
    if (mode == RC_RING) begin
      return ($countones(q & rc_mask(width)) == 1);
    end
    edges = (q ^ (q >> 1)) & rc_mask(width - 1);
    return ($countones(edges) <= 1);
  endfunction

endpackage

// File: rtl/ring_state_check.sv
// Combinational legality checker for the ring counter state.
// Only instantiated when RING_CNT_ERR_DETECT_EN is defined.
module ring_state_check
  import ring_counter_pkg::*;
#(
  parameter int C_WIDTH = 4
) (
  input  logic [C_WIDTH-1:0] q,
  input  logic               mode,
  output logic               illegal
);

  rc_vec_t q_ext;

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    q_ext              = '0;
    q_ext[C_WIDTH-1:0] = q;
    illegal            = !rc_legal(q_ext, rc_mode_e'(mode), C_WIDTH);
  end

endmodule

// File: rtl/ring_counter_mm.sv
// Multi-mode (one-hot ring / Johnson) up/down counter with preload, terminal count and revolution counter.
// Optional illegal-state recovery and sticky ERR flag under macro RING_CNT_ERR_DETECT_EN.
module ring_counter_mm
  import ring_counter_pkg::*;
#(
  parameter int C_WIDTH    = 4,
  parameter int C_REV_BITS = 8
) (
  input  logic                  CK,
  input  logic                  RST,
  input  logic                  EN,
  input  logic                  DIR,
  input  logic                  MODE,
  input  logic                  LOAD,
  input  logic [C_WIDTH-1:0]    LOAD_VAL,
  output logic [C_WIDTH-1:0]    Q,
  output logic                  TC,
  output logic [C_REV_BITS-1:0] REV_CNT,
  output logic                  ERR
);

  rc_mode_e              mode_q, mode_in, mode_d;
  logic [C_WIDTH-1:0]    q, q_d, nxt, home_cur, home_new;
  logic [C_REV_BITS-1:0] rev_cnt, rev_d;
  logic                  mode_switch, tc, illegal;

  rc_vec_t q_ext, nxt_ext, home_cur_ext, home_new_ext;

  assign mode_in     = rc_mode_e'(MODE);
  assign mode_switch = (mode_in != mode_q);

  always_comb begin
    q_ext              = '0;
    q_ext[C_WIDTH-1:0] = q;
    nxt_ext            = rc_next(q_ext, mode_q, DIR, C_WIDTH);
    home_cur_ext       = rc_home(mode_q, C_WIDTH);
    home_new_ext       = rc_home(mode_in, C_WIDTH);
    nxt                = nxt_ext[C_WIDTH-1:0];
    home_cur           = home_cur_ext[C_WIDTH-1:0];
    home_new           = home_new_ext[C_WIDTH-1:0];
  end

  // A mode change takes one edge of its own, so the terminal count is masked for that edge.
  assign tc = EN & ~LOAD & ~mode_switch & (nxt == home_cur);

`ifdef RING_CNT_ERR_DETECT_EN
  logic err_q;

  ring_state_check #(
    .C_WIDTH(C_WIDTH)
  ) u_state_check (
    .q      (q),
    .mode   (logic'(mode_q)),
    .illegal(illegal)
  );

  always_ff @(posedge CK or negedge RST) begin
    if (!RST) begin
      err_q <= 1'b0;
    end else if (illegal) begin
      err_q <= 1'b1;
    end
  end

  assign ERR = err_q;
`else
  assign illegal = 1'b0;
  assign ERR     = 1'b0;
`endif

  // Priority: preload, mode switch, illegal-state recovery, advance, hold.
  always_comb begin
    q_d    = q;
    mode_d = mode_q;
    rev_d  = rev_cnt;
    if (LOAD) begin
      q_d = LOAD_VAL;
    end else if (mode_switch) begin
      q_d    = home_new;
      mode_d = mode_in;
      rev_d  = '0;
    end else if (illegal) begin
      q_d = home_cur;
    end else if (EN) begin
      q_d = nxt;
      if (tc) begin
        rev_d = rev_cnt + C_REV_BITS'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CK or negedge RST) begin
    if (!RST) begin
      q       <= C_WIDTH'(1);
      mode_q  <= RC_RING;
      rev_cnt <= '0;
    end else begin
      q       <= q_d;
      mode_q  <= mode_d;
      rev_cnt <= rev_d;
    end
  end

  assign Q       = q;
  assign TC      = tc;
  assign REV_CNT = rev_cnt;

endmodule

// File: tb/tb_ring_counter_mm.sv
// Self-checking bench for ring_counter_mm (C_WIDTH=4, C_REV_BITS=2) using a queued scoreboard.
// Expectations for the illegal-state case follow RING_CNT_ERR_DETECT_EN.
module tb_ring_counter_mm;

  logic       CK = 1'b0;
  logic       RST = 1'b0;
  logic       EN = 1'b0;
  logic       DIR = 1'b0;
  logic       MODE = 1'b0;
  logic       LOAD = 1'b0;
  logic [3:0] LOAD_VAL = 4'b0000;
  logic [3:0] Q;
  logic       TC;
  logic [1:0] REV_CNT;
  logic       ERR;

  ring_counter_mm #(
    .C_WIDTH   (4),
    .C_REV_BITS(2)
  ) dut (
    .CK      (CK),
    .RST     (RST),
    .EN      (EN),
    .DIR     (DIR),
    .MODE    (MODE),
    .LOAD    (LOAD),
    .LOAD_VAL(LOAD_VAL),
    .Q       (Q),
    .TC      (TC),
    .REV_CNT (REV_CNT),
    .ERR     (ERR)
  );

  always #5 CK = ~CK;

  typedef struct {
    logic [3:0] q;
    logic [1:0] rev;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         tc_count = 0;

  logic [3:0] m_q;
  logic       m_mode;
  logic [1:0] m_rev;
  logic       m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_next(logic [3:0] q, logic mode, logic dir);
    case ({mode, dir})
      2'b00:   return {q[2:0], q[3]};
      2'b01:   return {q[0], q[3:1]};
      2'b10:   return {q[2:0], ~q[3]};
      default: return {~q[0], q[3:1]};
    endcase
  endfunction

  function automatic logic [3:0] m_home(logic mode);
    return mode ? 4'b0000 : 4'b0001;
  endfunction

  function automatic logic m_legal(logic [3:0] q, logic mode);
    if (!mode) return q inside {4'b0001, 4'b0010, 4'b0100, 4'b1000};
    return q inside {4'b0000, 4'b0001, 4'b0011, 4'b0111,
                     4'b1111, 4'b1110, 4'b1100, 4'b1000};
  endfunction

  task automatic model_reset();
    m_q    = 4'b0001;
    m_mode = 1'b0;
    m_rev  = 2'd0;
    m_err  = 1'b0;
    sb.delete();
  endtask

  // Reset asserted mid-cycle to exercise the asynchronous path.
  task automatic do_reset();
    @(negedge CK);
    #2;
    RST = 1'b0; EN = 1'b0; DIR = 1'b0; MODE = 1'b0; LOAD = 1'b0; LOAD_VAL = 4'b0000;
    #1;
    check("rst_q", Q, 4'b0001);
    check("rst_rev", REV_CNT, 2'd0);
    check("rst_err", ERR, 1'b0);
    model_reset();
    @(negedge CK);
    RST = 1'b1;
  endtask

  task automatic cyc(input logic en, input logic dir, input logic mode,
                     input logic load, input logic [3:0] lv);
    logic [3:0] nq;
    logic       tc_e;
    logic       ill;
    exp_t       e;
    @(negedge CK);
    EN = en; DIR = dir; MODE = mode; LOAD = load; LOAD_VAL = lv;
    #1;
    nq   = m_next(m_q, m_mode, dir);
    tc_e = en & ~load & (mode == m_mode) & (nq == m_home(m_mode));
    check("tc", TC, tc_e);
    if (TC) tc_count++;
    ill = 1'b0;
`ifdef RING_CNT_ERR_DETECT_EN
    ill = !m_legal(m_q, m_mode);
`endif
    if (load) begin
      m_q = lv;
    end else if (mode != m_mode) begin
      m_q    = m_home(mode);
      m_mode = mode;
      m_rev  = 2'd0;
    end else if (ill) begin
      m_q = m_home(m_mode);
    end else if (en) begin
      m_q = nq;
      if (tc_e) m_rev = m_rev + 2'd1;
    end
    if (ill) m_err = 1'b1;
    sb.push_back('{q: m_q, rev: m_rev, err: m_err});
    @(posedge CK);
    #1;
    e = sb.pop_front();
    check("q", Q, e.q);
    check("rev", REV_CNT, e.rev);
    check("err", ERR, e.err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();

    // Ring up for two revolutions.
    do_reset();
    tc_count = 0;
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    check("t1_tc_count", tc_count, 2);
    check("t1_q", Q, 4'b0001);
    check("t1_rev", REV_CNT, 2'd2);

    // Johnson from reset: one switch edge then a full period of 8.
    do_reset();
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
    check("t2_switch_q", Q, 4'b0000);
    tc_count = 0;
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
    check("t2_tc_count", tc_count, 1);
    check("t2_q", Q, 4'b0000);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    check("t2_back_to_ring", Q, 4'b0001);

    // Direction reversal mid-revolution.
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    tc_count = 0;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
    check("t3_q", Q, 4'b1000);
    check("t3_tc_count", tc_count, 1);

    // Preload wins over a pending terminal count.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'b0100);
    check("t4_load_rev", REV_CNT, 2'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    check("t4_rev", REV_CNT, 2'd1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);

    // Sixteen revolutions wrap the 2-bit revolution counter.
    do_reset();
    for (int i = 0; i < 64; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    check("t5_rev_wrap", REV_CNT, 2'd0);

    // Random mix of enable, direction, mode and occasional preload.
    do_reset();
    for (int i = 0; i < 60; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 11) == 0),
          4'($urandom_range(0, 15)));
    end

    // Illegal preload in ring mode.
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'b0110);
    check("t6_loaded", Q, 4'b0110);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
`ifdef RING_CNT_ERR_DETECT_EN
    check("t6_recover_q", Q, 4'b0001);
    check("t6_err_set", ERR, 1'b1);
`else
    check("t6_shift_q", Q, 4'b1100);
    check("t6_err_clear", ERR, 1'b0);
`endif
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    do_reset();
    check("t6_err_after_rst", ERR, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
